// File: rtl/sbox_check_unit.sv
// sbox_check_unit
// Checker placed directly downstream of a masked AES S-box observation point.
// Recombines the shared 4-byte input and output buses, delays every accepted
// input word by the S-box latency, compares it against the AES forward S-box,
// keeps saturating pass/fail statistics and captures the first mismatch.
//
// Optional feature macro: SBOX_CHECK_LANE_CNT_EN adds per-lane error counters.
//
// Ports
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   clear             synchronous flush of pipeline, counters and capture
//   in_valid          sh_4bytes_to_SB holds a new S-box input word
//   sh_4bytes_to_SB   shared S-box input (4 bytes, d shares per bit)
//   sh_4bytes_from_SB shared S-box output (4 bytes, d shares per bit)
//   busy              at least one word in flight (combinational from state)
//   ok_count          words with all 4 lanes correct
//   err_count         words with at least one lane wrong
//   error             sticky mismatch flag
//   first_err_lane    lowest mismatching lane of the first bad word
//   first_err_in      recombined input byte of that lane
//   first_err_got     recombined output byte of that lane
//   lane_err_count    per-lane mismatch counters, lane k at [CW*k +: CW]
//                     (only with SBOX_CHECK_LANE_CNT_EN)
module sbox_check_unit #(
   parameter int unsigned d   = 2,
   parameter int unsigned LAT = 4,
   parameter int unsigned CW  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [32*d-1:0]   sh_4bytes_to_SB,
   input  logic [32*d-1:0]   sh_4bytes_from_SB,
   output logic              busy,
   output logic [CW-1:0]     ok_count,
   output logic [CW-1:0]     err_count,
   output logic              error,
   output logic [1:0]        first_err_lane,
   output logic [7:0]        first_err_in,
   output logic [7:0]        first_err_got
`ifdef SBOX_CHECK_LANE_CNT_EN
   ,
   output logic [4*CW-1:0]   lane_err_count
`endif
);

   localparam int unsigned WW = 32;

   // AES forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // 255-x equals ~x for a byte, so the table offset is {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   // XOR the d shares of every bit back into a plain 32-bit word.
   function automatic logic [WW-1:0] recombine(input logic [32*d-1:0] bus);
      logic [WW-1:0] w;
      w = '0;
      for (int unsigned k = 0; k < 4; k++)
         for (int unsigned i = 0; i < 8; i++)
            for (int unsigned s = 0; s < d; s++)
               w[8*k+i] = w[8*k+i] ^ bus[8*d*k + d*i + s];
      return w;
   endfunction

   logic [WW-1:0]  in_word;
   logic [WW-1:0]  got_word;
   logic [WW-1:0]  pipe [LAT];
   logic [LAT-1:0] vld;
   logic [WW-1:0]  head;
   logic           emerge;
   logic [3:0]     mism;
   logic [1:0]     lo_lane;
   logic [7:0]     lo_in;
   logic [7:0]     lo_got;
   logic [7:0]     exp_byte;

   assign in_word  = recombine(sh_4bytes_to_SB);
   assign got_word = recombine(sh_4bytes_from_SB);
   assign head     = pipe[LAT-1];
   assign emerge   = vld[LAT-1];
   assign busy     = |vld;

   // Per-lane compare of the emerging word; descending scan leaves the lowest bad lane.
   always_comb begin
      mism     = '0;
      lo_lane  = '0;
      lo_in    = '0;
      lo_got   = '0;
      exp_byte = '0;
      for (int k = 3; k >= 0; k--) begin
         exp_byte = sbox(head[8*k +: 8]);
         if (exp_byte != got_word[8*k +: 8]) begin
            mism[k] = 1'b1;
            lo_lane = 2'(k);
            lo_in   = head[8*k +: 8];
            lo_got  = got_word[8*k +: 8];
         end
      end
   end

   // Latency-matching pipeline of recombined input words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
      end else if (clear) begin
         vld <= '0;
      end else begin
         vld[0]  <= in_valid;
         pipe[0] <= in_word;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld[i]  <= vld[i-1];
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Word statistics and first-mismatch capture; counters saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_count       <= '0;
         err_count      <= '0;
         error          <= 1'b0;
         first_err_lane <= '0;
         first_err_in   <= '0;
         first_err_got  <= '0;
      end else if (clear) begin
         ok_count       <= '0;
         err_count      <= '0;
         error          <= 1'b0;
         first_err_lane <= '0;
         first_err_in   <= '0;
         first_err_got  <= '0;
      end else if (emerge) begin
         if (mism == 4'b0000) begin
            if (ok_count != {CW{1'b1}}) ok_count <= ok_count + CW'(1);
         end else begin
            if (err_count != {CW{1'b1}}) err_count <= err_count + CW'(1);
            error <= 1'b1;
            if (!error) begin
               first_err_lane <= lo_lane;
               first_err_in   <= lo_in;
               first_err_got  <= lo_got;
            end
         end
      end
   end

`ifdef SBOX_CHECK_LANE_CNT_EN
   logic [CW-1:0] lane_cnt [4];

   // Per-lane saturating mismatch counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) lane_cnt[k] <= '0;
      end else if (clear) begin
         for (int unsigned k = 0; k < 4; k++) lane_cnt[k] <= '0;
      end else if (emerge) begin
         for (int unsigned k = 0; k < 4; k++)
            if (mism[k] && (lane_cnt[k] != {CW{1'b1}}))
               lane_cnt[k] <= lane_cnt[k] + CW'(1);
      end
   end

   always_comb begin
      lane_err_count = '0;
      for (int unsigned k = 0; k < 4; k++) lane_err_count[CW*k +: CW] = lane_cnt[k];
   end
`endif

endmodule

// File: tb/tb_sbox_check_unit.sv
// tb_sbox_check_unit
// Directed bench for sbox_check_unit. A queue-based reference model, whose
// S-box is derived from GF(2^8) inversion plus the affine map, is checked
// against the DUT on every falling edge; literal expectations pin key points.
module tb_sbox_check_unit;

   localparam int unsigned D   = 2;
   localparam int unsigned LAT = 4;
   localparam int unsigned CW  = 4;
   localparam int          SAT = (1 << CW) - 1;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic [32*D-1:0]   to_sb = '0;
   logic [32*D-1:0]   from_sb = '0;
   logic              busy;
   logic [CW-1:0]     ok_count;
   logic [CW-1:0]     err_count;
   logic              error;
   logic [1:0]        first_err_lane;
   logic [7:0]        first_err_in;
   logic [7:0]        first_err_got;
`ifdef SBOX_CHECK_LANE_CNT_EN
   logic [4*CW-1:0]   lane_err_count;
`endif

   sbox_check_unit #(.d(D), .LAT(LAT), .CW(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .clear             (clear),
      .in_valid          (in_valid),
      .sh_4bytes_to_SB   (to_sb),
      .sh_4bytes_from_SB (from_sb),
      .busy              (busy),
      .ok_count          (ok_count),
      .err_count         (err_count),
      .error             (error),
      .first_err_lane    (first_err_lane),
      .first_err_in      (first_err_in),
      .first_err_got     (first_err_got)
`ifdef SBOX_CHECK_LANE_CNT_EN
      ,
      .lane_err_count    (lane_err_count)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
         if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] sbox_word(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_sbox(w[8*k +: 8]);
      return r;
   endfunction

   // Random d-way sharing of a plain word.
   function automatic logic [32*D-1:0] share(input logic [31:0] w);
      logic [32*D-1:0] bus;
      logic acc;
      bus = '0;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++) begin
            acc = w[8*k+i];
            for (int s = 0; s < D-1; s++) begin
               bus[8*D*k + D*i + s] = 1'($urandom_range(1, 0));
               acc = acc ^ bus[8*D*k + D*i + s];
            end
            bus[8*D*k + D*i + D-1] = acc;
         end
      return bus;
   endfunction

   function automatic logic [31:0] unshare(input logic [32*D-1:0] bus);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 32; b++)
         for (int s = 0; s < D; s++) w[b] = w[b] ^ bus[D*b + s];
      return w;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {int due; logic [31:0] w;} pend_t;
   pend_t q[$];
   int mcyc = 0;
   int m_ok = 0, m_err = 0;
   logic m_error = 1'b0;
   logic [1:0] m_lane = '0;
   logic [7:0] m_in = '0, m_got = '0;
   int m_lc [4] = '{0, 0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ok = 0; m_err = 0; m_error = 1'b0;
         m_lane = '0; m_in = '0; m_got = '0;
         foreach (m_lc[k]) m_lc[k] = 0;
      end else begin
         pend_t it;
         logic [31:0] got;
         logic bad;
         logic [1:0] bl;
         logic [7:0] bi, bg, e;
         mcyc++;
         got = unshare(from_sb);
         if (q.size() > 0 && q[0].due == mcyc) begin
            it = q.pop_front();
            if (!clear) begin
               bad = 1'b0; bl = '0; bi = '0; bg = '0;
               for (int k = 0; k < 4; k++) begin
                  e = ref_sbox(it.w[8*k +: 8]);
                  if (e != got[8*k +: 8]) begin
                     if (!bad) begin bl = 2'(k); bi = it.w[8*k +: 8]; bg = got[8*k +: 8]; end
                     bad = 1'b1;
                     if (m_lc[k] < SAT) m_lc[k]++;
                  end
               end
               if (bad) begin
                  if (m_err < SAT) m_err++;
                  if (!m_error) begin m_lane = bl; m_in = bi; m_got = bg; end
                  m_error = 1'b1;
               end else if (m_ok < SAT) m_ok++;
            end
         end
         if (clear) begin
            q.delete();
            m_ok = 0; m_err = 0; m_error = 1'b0;
            m_lane = '0; m_in = '0; m_got = '0;
            foreach (m_lc[k]) m_lc[k] = 0;
         end else if (in_valid) begin
            q.push_back('{mcyc + LAT, unshare(to_sb)});
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 32'(busy), 32'(q.size() != 0));
         chk("ok_count", 32'(ok_count), 32'(m_ok));
         chk("err_count", 32'(err_count), 32'(m_err));
         chk("error", 32'(error), 32'(m_error));
         chk("first_err_lane", 32'(first_err_lane), 32'(m_lane));
         chk("first_err_in", 32'(first_err_in), 32'(m_in));
         chk("first_err_got", 32'(first_err_got), 32'(m_got));
`ifdef SBOX_CHECK_LANE_CNT_EN
         for (int k = 0; k < 4; k++)
            chk("lane_err_count", 32'(lane_err_count[CW*k +: CW]), 32'(m_lc[k]));
`endif
      end
   end

   // ---------------- stimulus ----------------
   int tcyc = 0;
   logic [31:0] sched [int];

   // Drive one cycle; a valid word's output is scheduled LAT cycles later.
   task automatic step(input logic v, input logic [31:0] inw, input logic [31:0] outw,
                       input logic clr);
      @(posedge clk);
      tcyc++;
      #1;
      in_valid = v;
      clear    = clr;
      to_sb    = share(inw);
      if (v) sched[tcyc + LAT] = outw;
      if (sched.exists(tcyc)) begin
         from_sb = share(sched[tcyc]);
         sched.delete(tcyc);
      end else begin
         from_sb = share($urandom());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_clear();
      step(1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] W1_IN  = 32'hFF015300;
   localparam logic [31:0] W1_OUT = 32'h167CED63;

   initial begin
      logic [31:0] w;
      #2;
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_ok", 32'(ok_count), 32'h0);
      chk("reset_error", 32'(error), 32'h0);
      chk("ref_sbox_53", 32'(ref_sbox(8'h53)), 32'hED);
      chk("ref_sbox_00", 32'(ref_sbox(8'h00)), 32'h63);
      #10 rst_n = 1'b1;

      // 1: single good word
      step(1'b1, W1_IN, W1_OUT, 1'b0);
      idle(1);
      chk("t1_busy_in_flight", 32'(busy), 32'h1);
      idle(5);
      chk("t1_ok", 32'(ok_count), 32'h1);
      chk("t1_err", 32'(err_count), 32'h0);
      chk("t1_busy_done", 32'(busy), 32'h0);

      // 2: lane 2 wrong
      step(1'b1, W1_IN, 32'h167DED63, 1'b0);
      idle(6);
      chk("t2_err", 32'(err_count), 32'h1);
      chk("t2_error", 32'(error), 32'h1);
      chk("t2_lane", 32'(first_err_lane), 32'h2);
      chk("t2_in", 32'(first_err_in), 32'h01);
      chk("t2_got", 32'(first_err_got), 32'h7D);

      // 3: 10 back-to-back good words
      do_clear();
      for (int i = 0; i < 10; i++) begin
         w = $urandom();
         step(1'b1, w, sbox_word(w), 1'b0);
      end
      idle(4);
      chk("t3_ok_before", 32'(ok_count), 32'd9);
      idle(1);
      chk("t3_ok_exact", 32'(ok_count), 32'd10);
      chk("t3_no_err", 32'(err_count), 32'h0);

      // 4: bad lane 3, then bad lane 0
      do_clear();
      step(1'b1, W1_IN, W1_OUT ^ 32'h01000000, 1'b0);
      step(1'b1, W1_IN, W1_OUT ^ 32'h00000001, 1'b0);
      idle(6);
      chk("t4_err", 32'(err_count), 32'd2);
      chk("t4_lane", 32'(first_err_lane), 32'h3);
      chk("t4_got", 32'(first_err_got), 32'h17);

      // lowest lane of a multi-lane mismatch
      do_clear();
      step(1'b1, W1_IN, W1_OUT ^ 32'h8000_8000, 1'b0);
      idle(6);
      chk("multi_lane", 32'(first_err_lane), 32'h1);
      chk("multi_in", 32'(first_err_in), 32'h53);

      // 6a: asynchronous reset mid-stream
      step(1'b1, W1_IN, W1_OUT, 1'b0);
      step(1'b1, W1_IN, W1_OUT, 1'b0);
      @(posedge clk);
      tcyc++;
      #3 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_err", 32'(err_count), 32'h0);
      chk("arst_error", 32'(error), 32'h0);
      chk("arst_lane", 32'(first_err_lane), 32'h0);
      chk("arst_in", 32'(first_err_in), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      sched.delete();
      idle(7);
      chk("arst_dropped", 32'(ok_count), 32'h0);

      // 5: clear with two words in flight, plus a word offered during clear
      step(1'b1, W1_IN, 32'h0, 1'b0);
      step(1'b1, W1_IN, 32'h0, 1'b0);
      step(1'b1, W1_IN, 32'h0, 1'b1);
      idle(1);
      chk("t5_busy", 32'(busy), 32'h0);
      idle(6);
      chk("t5_err", 32'(err_count), 32'h0);
      chk("t5_error", 32'(error), 32'h0);

      // 6b: saturation with 20 lane-1 errors, then 17 good words
      for (int i = 0; i < 20; i++) step(1'b1, W1_IN, W1_OUT ^ 32'h0000_0100, 1'b0);
      idle(6);
      chk("sat_err", 32'(err_count), 32'(SAT));
      chk("sat_lane", 32'(first_err_lane), 32'h1);
`ifdef SBOX_CHECK_LANE_CNT_EN
      chk("sat_lane1_cnt", 32'(lane_err_count[CW +: CW]), 32'(SAT));
      chk("sat_lane0_cnt", 32'(lane_err_count[0 +: CW]), 32'h0);
`endif
      for (int i = 0; i < 17; i++) begin
         w = $urandom();
         step(1'b1, w, sbox_word(w), 1'b0);
      end
      idle(6);
      chk("sat_ok", 32'(ok_count), 32'(SAT));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
